// File: rtl/ex_mem_flags_stage.sv
// ex_mem_flags_stage: EX/MEM pipeline register with NZCV flag register and branch resolution
module ex_mem_flags_stage #(
  parameter int N  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_e,
  input  logic [N-1:0]  ALUResult_e,
  input  logic [3:0]    ALUFlags_e,
  input  logic          FlagWrite_e,
  input  logic          CondBranch_e,
  input  logic [2:0]    Cond_e,
  input  logic          RegWrite_e,
  input  logic          MemWrite_e,
  input  logic [RA-1:0] Rd_e,
  input  logic [N-1:0]  WriteData_e,
  output logic [N-1:0]  ALUResult_m,
  output logic [N-1:0]  WriteData_m,
  output logic [RA-1:0] Rd_m,
  output logic          RegWrite_m,
  output logic          MemWrite_m,
  output logic          valid_m,
  output logic          BranchTaken_m,
  output logic [3:0]    Flags_q
);
  logic       fw;
  logic [3:0] f;
  logic       lt;
  logic [7:0] cond_tab;
  logic       taken;
  // a flag-writing branch resolves against its own fresh flags
  always_comb begin
    fw       = valid_e & FlagWrite_e;
    f        = fw ? ALUFlags_e : Flags_q;
    lt       = f[3] ^ f[0];
    cond_tab = {1'b0, 1'b1, f[2] | lt, ~f[2] & ~lt, ~lt, lt, ~f[2], f[2]};
    taken    = valid_e & CondBranch_e & cond_tab[Cond_e];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ALUResult_m   <= '0;
      WriteData_m   <= '0;
      Rd_m          <= '0;
      RegWrite_m    <= 1'b0;
      MemWrite_m    <= 1'b0;
      valid_m       <= 1'b0;
      BranchTaken_m <= 1'b0;
      Flags_q       <= 4'b0000;
    end else if (flush) begin
      ALUResult_m   <= '0;
      WriteData_m   <= '0;
      Rd_m          <= '0;
      RegWrite_m    <= 1'b0;
      MemWrite_m    <= 1'b0;
      valid_m       <= 1'b0;
      BranchTaken_m <= 1'b0;
    end else if (!stall) begin
      ALUResult_m   <= ALUResult_e;
      WriteData_m   <= WriteData_e;
      Rd_m          <= Rd_e;
      RegWrite_m    <= RegWrite_e & valid_e;
      MemWrite_m    <= MemWrite_e & valid_e;
      valid_m       <= valid_e;
      BranchTaken_m <= taken;
      if (fw) Flags_q <= ALUFlags_e;
    end
endmodule
